// File: rtl/conv2d_window_scheduler.sv
// conv2d_window_scheduler: walks a 3x3 window over a row-major image,
// assembles image_patch from pixel memory reads and streams datapath results.
// Ports: clk/rst, start+img_width/img_height config, busy/done/cfg_err status,
//   rd_en/rd_addr/rd_data pixel memory, patch to datapath, conv_result from
//   datapath, out_valid/out_ready/out_data/out_row/out_col result stream.
package conv2d_pkg;
   localparam int DATA_WIDTH   = 8;
   localparam int FILTER_SIZE  = 3;
   localparam int RESULT_WIDTH = 2 * DATA_WIDTH + 4;
endpackage

module conv2d_window_scheduler
   import conv2d_pkg::*;
#(
   parameter int DIM_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIM_WIDTH-1:0]    img_width,
   input  logic [DIM_WIDTH-1:0]    img_height,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] patch,
   input  logic [RESULT_WIDTH:0]   conv_result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RESULT_WIDTH:0]   out_data,
   output logic [DIM_WIDTH-1:0]    out_row,
   output logic [DIM_WIDTH-1:0]    out_col
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_SHIFT,
      S_COMPUTE,
      S_OUT,
      S_DONE
   } state_t;

   state_t                state;
   logic [DIM_WIDTH-1:0]  w_q;
   logic [DIM_WIDTH-1:0]  h_q;
   logic [DIM_WIDTH-1:0]  r_q;
   logic [DIM_WIDTH-1:0]  c_q;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] w_a;
   logic [1:0]            ri;
   logic [1:0]            rj;
   logic [1:0]            ni;
   logic [1:0]            nj;
   logic                  rd_last;
   logic                  wr_vld;
   logic [1:0]            wr_i;
   logic [1:0]            wr_j;
   logic [63:0]           area;
   logic                  legal;

   assign w_a   = ADDR_WIDTH'(w_q);
   assign area  = 64'(img_width) * 64'(img_height);
   assign legal = (img_width >= DIM_WIDTH'(3)) &&
                  (img_height >= DIM_WIDTH'(3)) &&
                  (area <= (64'd1 << ADDR_WIDTH));

   // Read order: i walks down a column, then j steps right (FILL only;
   // SHIFT stays in column 2 and ends after i=2).
   always_comb begin
      ni = ri + 2'd1;
      nj = rj;
      if (ri == 2'd2) begin
         ni = 2'd0;
         nj = rj + 2'd1;
      end
      rd_last = (ri == 2'd2) && ((state == S_SHIFT) || (rj == 2'd2));
   end

   // (base + i*W + col) built from adds and a shift only.
   function automatic logic [ADDR_WIDTH-1:0] pix_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [ADDR_WIDTH-1:0] w,
      input logic [1:0]            i,
      input logic [DIM_WIDTH-1:0]  col
   );
      logic [ADDR_WIDTH-1:0] off;
      off = '0;
      if (i == 2'd1) off = w;
      if (i == 2'd2) off = w << 1;
      return base + off + ADDR_WIDTH'(col);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         w_q       <= '0;
         h_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         row_base  <= '0;
         ri        <= '0;
         rj        <= '0;
         wr_vld    <= 1'b0;
         wr_i      <= '0;
         wr_j      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         patch     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         // Returning read data lands one cycle after its strobe.
         wr_vld  <= rd_en;
         wr_i    <= ri;
         wr_j    <= rj;
         if (wr_vld) patch[wr_i][wr_j] <= rd_data;
         unique case (state)
            S_IDLE: begin
               if (start && legal) begin
                  w_q      <= img_width;
                  h_q      <= img_height;
                  r_q      <= '0;
                  c_q      <= '0;
                  row_base <= '0;
                  ri       <= '0;
                  rj       <= '0;
                  rd_addr  <= '0;
                  rd_en    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_FILL;
               end else if (start) begin
                  cfg_err <= 1'b1;
               end
            end
            S_FILL, S_SHIFT: begin
               if (rd_en) begin
                  if (rd_last) begin
                     rd_en <= 1'b0;
                  end else begin
                     ri      <= ni;
                     rj      <= nj;
                     rd_addr <= pix_addr(row_base, w_a, ni,
                                         c_q + DIM_WIDTH'(nj));
                  end
               end else begin
                  state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               out_data  <= conv_result;
               out_row   <= r_q;
               out_col   <= c_q;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (c_q < w_q - DIM_WIDTH'(3)) begin
                     // Slide right: keep two columns, fetch the new third.
                     for (int i = 0; i < FILTER_SIZE; i++) begin
                        patch[i][0] <= patch[i][1];
                        patch[i][1] <= patch[i][2];
                     end
                     c_q     <= c_q + DIM_WIDTH'(1);
                     ri      <= 2'd0;
                     rj      <= 2'd2;
                     rd_addr <= pix_addr(row_base, w_a, 2'd0,
                                         c_q + DIM_WIDTH'(3));
                     rd_en   <= 1'b1;
                     state   <= S_SHIFT;
                  end else if (r_q < h_q - DIM_WIDTH'(3)) begin
                     r_q      <= r_q + DIM_WIDTH'(1);
                     c_q      <= '0;
                     row_base <= row_base + w_a;
                     rd_addr  <= row_base + w_a;
                     ri       <= 2'd0;
                     rj       <= 2'd0;
                     rd_en    <= 1'b1;
                     state    <= S_FILL;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// tb_conv2d_window_scheduler: directed and randomized frames checked
// against a plain-arithmetic convolution model and timing rules.
module tb_conv2d_window_scheduler;
   import conv2d_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int RW = RESULT_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    img_width;
   logic [7:0]    img_height;
   logic          busy;
   logic          done;
   logic          cfg_err;
   logic          rd_en;
   logic [15:0]   rd_addr;
   logic [DW-1:0] rd_data;
   logic [2:0][2:0][DW-1:0] patch;
   logic [RW:0]   conv_result;
   logic          out_valid;
   logic          out_ready;
   logic [RW:0]   out_data;
   logic [7:0]    out_row;
   logic [7:0]    out_col;

   logic [DW-1:0] mem [65536];
   int            filt [3][3];
   longint        acc;
   int            tests_run;
   int            tests_failed;
   logic [RW:0]   got_data [$];
   int            got_row [$];
   int            got_col [$];
   int            exp_sweep [6] = '{6, 7, 8, 11, 12, 13};

   always #5 clk = ~clk;

   conv2d_window_scheduler #(.DIM_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .img_width(img_width), .img_height(img_height),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .patch(patch), .conv_result(conv_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_col(out_col)
   );

   always @(posedge clk)
      rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);

   always_comb begin
      acc = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            acc += longint'(patch[i][j]) * longint'(filt[i][j]);
      conv_result = acc[RW:0];
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint ref_out(int w, int r, int c);
      longint s = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s += longint'(mem[(r + i) * w + c + j]) * filt[i][j];
      return s;
   endfunction

   function automatic logic [63:0] got_at(int k);
      if (k < got_data.size()) return 64'(got_data[k]);
      return '1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, {busy, done, cfg_err, rd_en, out_valid}, 0);
      check({tag, "_addr"}, rd_addr, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_rc"}, {out_row, out_col}, 0);
      check({tag, "_patch"}, 64'(patch == '0), 1);
   endtask

   task automatic run_frame(input int w, input int h, input int stall,
                            input int abort_row, input int spur);
      int          cyc, last_hs, n_reads, bad_hold, bad_stall, bad_lat;
      int          n_err, stall_cnt, exp_lat, n;
      bit          seen_done, pv;
      logic [15:0] prev_addr;
      logic [RW:0] hold_d;
      logic [7:0]  hold_r, hold_c;
      got_data.delete();
      got_row.delete();
      got_col.delete();
      {n_reads, bad_hold, bad_stall, bad_lat, n_err, stall_cnt} = '0;
      seen_done = 0;
      pv = 0;
      hold_d = '0;
      hold_r = '0;
      hold_c = '0;
      @(negedge clk);
      img_width = 8'(w);
      img_height = 8'(h);
      start = 1'b1;
      prev_addr = rd_addr;
      last_hs = 0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 4000) begin
         if (rd_en) n_reads++;
         else if (rd_addr !== prev_addr) bad_hold++;
         prev_addr = rd_addr;
         if (cfg_err) n_err++;
         if (done) begin
            seen_done = 1;
            check("done_after_hs", cyc, last_hs + 1);
            img_width = 8'd5;
            img_height = 8'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_at_done_ignored", {busy, rd_en, done}, 0);
            break;
         end
         if (abort_row >= 0 && out_valid && int'(out_row) == abort_row) begin
            start = 1'b0;
            rst = 1'b1;
            return;
         end
         if (out_valid) begin
            if (!pv) begin
               exp_lat = (out_col == 0) ? 12 : 6;
               if (cyc - last_hs != exp_lat) bad_lat++;
               hold_d = out_data;
               hold_r = out_row;
               hold_c = out_col;
               stall_cnt = 0;
            end else if (out_data !== hold_d || out_row !== hold_r ||
                         out_col !== hold_c) begin
               bad_stall++;
            end
            if (rd_en) bad_stall++;
            if (stall_cnt < stall) begin
               out_ready = 1'b0;
               stall_cnt++;
               pv = 1;
            end else begin
               out_ready = 1'b1;
               got_data.push_back(out_data);
               got_row.push_back(int'(out_row));
               got_col.push_back(int'(out_col));
               last_hs = cyc;
               pv = 0;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            pv = 0;
         end
         if (cyc == spur) begin
            img_width = 8'($urandom_range(0, 9));
            img_height = 8'($urandom_range(0, 9));
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check("frame_done", seen_done, 1);
      check("cfg_err_quiet", n_err, 0);
      check("addr_hold", bad_hold, 0);
      check("stall_hold", bad_stall, 0);
      check("latency", bad_lat, 0);
      check("n_reads", n_reads, 9 * (h - 2) + 3 * (w - 3) * (h - 2));
      check("n_outputs", got_data.size(), (w - 2) * (h - 2));
      n = got_data.size();
      for (int k = 0; k < n; k++) begin
         check("out_data", got_data[k], ref_out(w, k / (w - 2), k % (w - 2)));
         check("out_pos", {got_row[k], got_col[k]},
               {k / (w - 2), k % (w - 2)});
      end
      @(negedge clk);
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      start = 1'b0;
      img_width = '0;
      img_height = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) filt[i][j] = 0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("idle");

      for (int a = 0; a < 9; a++) mem[a] = DW'(a + 1);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) filt[i][j] = 1;
      run_frame(3, 3, 0, -1, -1);
      check("single_45", got_at(0), 45);

      for (int a = 0; a < 20; a++) mem[a] = DW'(a);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) filt[i][j] = (i == 1 && j == 1) ? 1 : 0;
      run_frame(5, 4, 0, -1, -1);
      for (int k = 0; k < 6; k++) check("sweep", got_at(k), exp_sweep[k]);

      run_frame(5, 4, 5, -1, 20);
      for (int k = 0; k < 6; k++) check("bp_sweep", got_at(k), exp_sweep[k]);

      @(negedge clk);
      img_width = 8'd2;
      img_height = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("cfg_err_pulse", {cfg_err, busy}, 2'b10);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n += int'(cfg_err) + int'(busy) + int'(rd_en);
      end
      check("cfg_err_idle", n, 0);

      for (int a = 0; a < 36; a++) mem[a] = DW'($urandom);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) filt[i][j] = $urandom_range(0, 255);
      run_frame(6, 6, 0, 1, -1);
      @(negedge clk);
      rst = 1'b0;
      check_zero("abort");
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n += int'(done) + int'(busy) + int'(rd_en) + int'(out_valid);
      end
      check("abort_quiet", n, 0);
      for (int a = 0; a < 20; a++) mem[a] = DW'($urandom);
      run_frame(4, 5, 2, -1, 30);

      for (int a = 0; a < 9; a++) mem[a] = '1;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) filt[i][j] = 255;
      run_frame(3, 3, 0, -1, -1);
      check("max_value", got_at(0), 9 * 255 * 255);

      for (int t = 0; t < 3; t++) begin
         int w, h;
         w = $urandom_range(3, 7);
         h = $urandom_range(3, 7);
         for (int a = 0; a < w * h; a++) mem[a] = DW'($urandom);
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) filt[i][j] = $urandom_range(0, 255);
         run_frame(w, h, $urandom_range(0, 3), -1, $urandom_range(2, 25));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
